// File: rtl/hs_npu_memory_interface.sv
// Bridge from the NPU memory-ordering stage to an Avalon-MM burst master.
// Reads gather one line of beats into read_data_o; writes serialise a latched line.
module hs_npu_memory_interface #(
   parameter int unsigned SIZE           = 8,
   parameter int unsigned WORDS_PER_LINE = SIZE * 8 / 32,
   parameter int unsigned BURST_WIDTH    = $clog2(WORDS_PER_LINE) + 1
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                read_ready_i,
   input  logic                                write_valid_i,
   input  logic [31:0]                         request_address_i,
   input  logic [WORDS_PER_LINE-1:0][31:0]     write_data_i,
   output logic [WORDS_PER_LINE-1:0][31:0]     read_data_o,
   output logic                                mem_valid_o,
   output logic                                mem_ready_o,
   output logic [31:0]                         avm_address,
   output logic                                avm_read,
   output logic                                avm_write,
   output logic [BURST_WIDTH-1:0]              avm_burstcount,
   output logic [3:0]                          avm_byteenable,
   output logic [31:0]                         avm_writedata,
   input  logic [31:0]                         avm_readdata,
   input  logic                                avm_readdatavalid,
   input  logic                                avm_waitrequest
);

   localparam int unsigned IdxW = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
   localparam logic [IdxW-1:0] LastIdx = IdxW'(WORDS_PER_LINE - 1);

   typedef enum logic [2:0] {
      StIdle,
      StRdReq,
      StRdData,
      StRdDone,
      StWrBurst
   } state_e;

   state_e                          state_q, state_d;
   logic [IdxW-1:0]                 cnt_q, cnt_d;
   logic [31:0]                     addr_q, addr_d;
   logic [WORDS_PER_LINE-1:0][31:0] wline_q, wline_d;
   logic [WORDS_PER_LINE-1:0][31:0] rdata_q, rdata_d;
   logic                            beat_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         addr_q  <= '0;
         wline_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wline_q <= wline_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      wline_d   = wline_q;
      rdata_d   = rdata_q;
      beat_last = (cnt_q == LastIdx);
      unique case (state_q)
         StIdle: begin
            if (write_valid_i) begin
               addr_d  = request_address_i;
               wline_d = write_data_i;
               state_d = StWrBurst;
            end else if (read_ready_i) begin
               addr_d  = request_address_i;
               state_d = StRdReq;
            end
         end
         StRdReq: begin
            // A fast slave may return the first beat in the accept cycle itself.
            if (avm_readdatavalid) begin
               rdata_d[cnt_q] = avm_readdata;
               cnt_d          = beat_last ? '0 : cnt_q + IdxW'(1);
            end
            if (!avm_waitrequest) begin
               state_d = (avm_readdatavalid && beat_last) ? StRdDone : StRdData;
            end
         end
         StRdData: begin
            if (avm_readdatavalid) begin
               rdata_d[cnt_q] = avm_readdata;
               if (beat_last) begin
                  cnt_d   = '0;
                  state_d = StRdDone;
               end else begin
                  cnt_d = cnt_q + IdxW'(1);
               end
            end
         end
         StRdDone: begin
            state_d = StIdle;
         end
         StWrBurst: begin
            if (!avm_waitrequest) begin
               if (beat_last) begin
                  cnt_d   = '0;
                  state_d = StIdle;
               end else begin
                  cnt_d = cnt_q + IdxW'(1);
               end
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
   end

   assign avm_read       = (state_q == StRdReq);
   assign avm_write      = (state_q == StWrBurst);
   assign avm_burstcount = (avm_read || avm_write) ? BURST_WIDTH'(WORDS_PER_LINE) : '0;
   assign avm_address    = (avm_read || avm_write) ? addr_q : '0;
   assign avm_writedata  = avm_write ? wline_q[cnt_q] : '0;
   assign avm_byteenable = 4'hF;
   assign mem_valid_o    = (state_q == StRdDone);
   // Gated by reset so every handshake output reads 0 while reset is held.
   assign mem_ready_o    = rst_n && (state_q == StIdle);
   assign read_data_o    = rdata_q;

endmodule

// File: doc/hs_npu_memory_interface.md
Name: hs_npu_memory_interface

Overview:
- Bus-side bridge directly downstream of the NPU memory-ordering stage.
- Turns the stage's line-granular read/write handshakes into Avalon-MM burst transactions of WORDS_PER_LINE 32-bit words.
- On reads, assembles the returned beats into one line and presents it back with a single-cycle valid pulse.
- On writes, serialises a latched line onto the bus.

Parameters:
- SIZE, 8, systolic array dimension.
- WORDS_PER_LINE, SIZE*8/32, 32-bit words per line and per burst.
- BURST_WIDTH, $clog2(WORDS_PER_LINE)+1, width of avm_burstcount.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock, asynchronous, active-low
- read_ready_i  in  1  ordering stage wants the line at request_address_i
- write_valid_i  in  1  ordering stage presents a line to write
- request_address_i  in  32  byte address of the line
- write_data_i  in  32 x WORDS_PER_LINE  line to write
- read_data_o  out  32 x WORDS_PER_LINE  assembled read line
- mem_valid_o  out  1  one-cycle pulse: read_data_o valid
- mem_ready_o  out  1  bridge idle, a write can be accepted
- avm_address  out  32  Avalon byte address
- avm_read  out  1  Avalon read request
- avm_write  out  1  Avalon write request
- avm_burstcount  out  BURST_WIDTH  always WORDS_PER_LINE while read/write asserted
- avm_byteenable  out  4  constant 4'hF
- avm_writedata  out  32  current write beat
- avm_readdata  in  32  read beat
- avm_readdatavalid  in  1  read beat valid
- avm_waitrequest  in  1  slave stall

Behaviour:
- Reset (asynchronous, any state):
  - state IDLE; beat counter 0.
  - All outputs 0 except avm_byteenable = 4'hF.
  - read_data_o and write line buffer cleared.
  - An in-flight burst is abandoned; nothing is replayed after reset.
- States: IDLE, RD_REQ, RD_DATA, RD_DONE, WR_BURST.
- mem_ready_o = (state == IDLE).
- IDLE:
  - write_valid_i high: latch address and write_data_i, go to WR_BURST. Write has priority if both requests are high.
  - Else read_ready_i high: latch address, go to RD_REQ.
- RD_REQ:
  - avm_read = 1, avm_address = latched address, avm_burstcount = WORDS_PER_LINE.
  - Held stable while avm_waitrequest = 1.
  - On the edge where waitrequest = 0: drop avm_read, go to RD_DATA.
  - A beat returned in that same cycle is captured.
- RD_DATA:
  - Each avm_readdatavalid beat is stored in read_data_o[counter], counter increments.
  - After beat WORDS_PER_LINE-1 is stored: counter clears, go to RD_DONE.
- RD_DONE:
  - mem_valid_o = 1 for exactly this one cycle; read_data_o is stable from here until the next read's first beat.
  - Next state IDLE.
  - A line is never delivered twice.
  - Back-to-back reads require the ordering stage to advance the address in the cycle mem_valid_o is high.
- readdatavalid outside RD_REQ/RD_DATA is ignored (no capture, no counter change).
- WR_BURST:
  - avm_write = 1, avm_burstcount = WORDS_PER_LINE, avm_address = latched address (held for the whole burst).
  - avm_writedata = line[counter].
  - A beat completes on each edge with waitrequest = 0; counter increments.
  - After the last beat: counter clears, avm_write drops, go to IDLE.
  - No completion pulse for writes; mem_ready_o returning high marks completion.
- Inputs are not sampled outside IDLE; request changes mid-transaction have no effect.
- Minimum read latency (no stalls, readdata one cycle after accept): request seen at edge N; avm_read high N+1; beats N+2..N+1+W; mem_valid_o at N+2+W.
- Minimum write occupancy: W cycles of avm_write, IDLE on the following cycle.

Test Plan:
- Read, no stalls, W=2, read_ready_i at 0x100, slave returns 0xAABBCCDD, 0x11223344 -> one avm_read at 0x100 with burstcount 2; mem_valid_o pulses once with read_data_o = {0xAABBCCDD, 0x11223344}; back to IDLE.
- Read with waitrequest high 3 cycles, then beats separated by 2-cycle gaps -> avm_read/address held 3 cycles; mem_valid_o only after the second beat; exactly one pulse.
- Write {0xDEADBEEF, 0x0000FFFF} to 0x200 with waitrequest high on the second beat for 2 cycles -> avm_write held at 0x200; writedata 0xDEADBEEF then 0x0000FFFF held through the stall; mem_ready_o low throughout and high the cycle after the last accept.
- read_ready_i and write_valid_i both high in IDLE -> write burst issued first; read issued after return to IDLE if still requested.
- Stray avm_readdatavalid with 0x5555 while IDLE, then a normal read -> stray beat ignored; delivered line holds only the real beats.
- rst_n low during RD_DATA after one beat -> all outputs 0 immediately; after release, a new read completes normally with the counter starting at 0.
